// File: rtl/spm_seq_ctrl.sv
// Sequencer and serial-parallel datapath for a signed NxN multiplier.
// Accepts a start pulse in IDLE and produces a held 2N-bit product with a done strobe.
module spm_seq_ctrl #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [2*N-1:0]   product,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(2 * N);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     mcand;
  logic [N-1:0]     mplier;
  logic [N+1:0]     psum;
  logic [N+1:0]     acc;
  logic [N+1:0]     mcand_ext;
  logic [2*N-1:0]   prod_sr;
  logic [CW-1:0]    cnt;
  logic             last;

  assign last      = (cnt == CW'(2 * N - 1));
  assign mcand_ext = {{2{mcand[N-1]}}, mcand};
  // Two guard bits: |psum| never exceeds |a|, so psum + a always fits in N+2 signed bits.
  assign acc       = psum + (mplier[0] ? mcand_ext : '0);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      psum    <= '0;
      prod_sr <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
          end
        end
        LOAD: begin
          psum    <= '0;
          prod_sr <= '0;
          cnt     <= '0;
        end
        RUN: begin
          // Arithmetic shift of the multiplier supplies sign-extension bits N..2N-1.
          mplier  <= {mplier[N-1], mplier[N-1:1]};
          psum    <= {acc[N+1], acc[N+1:1]};
          prod_sr <= {acc[0], prod_sr[2*N-1:1]};
          cnt     <= cnt + 1'b1;
          if (last) product <= {acc[0], prod_sr[2*N-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Directed self-checking bench for spm_seq_ctrl (N = 8).
module tb_spm_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        done;
  logic        busy;

  int checks;
  int failures;

  spm_seq_ctrl #(.N(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a start pulse that is sampled by the next rising edge (E0); returns just after E0.
  task automatic pulse_start(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after E0 until done is seen; -1 if the bound expires.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      a     = 8'($urandom);
      b     = 8'($urandom);
      checks++;
      if (product !== 16'h0000 || done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: product=%h done=%b busy=%b required 0000/0/0", product, done, busy);
      end
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (product !== 16'h0000 || done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_release: product=%h done=%b busy=%b required 0000/0/0", product, done, busy);
      end
    end
  endtask

  task automatic test_small;
    pulse_start(8'd5, 8'd3);
    for (int k = 0; k <= 19; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== (k <= 17) || done !== (k == 17)) begin
        failures++;
        $display("FAIL small_timing k=%0d: busy=%b done=%b required %b/%b", k, busy, done, k <= 17, k == 17);
      end
      if (k >= 17) begin
        checks++;
        if (product !== 16'h000F) begin
          failures++;
          $display("FAIL small_product k=%0d: got %h required 000f", k, product);
        end
      end
    end
  endtask

  task automatic test_mixed;
    int e;
    pulse_start(8'hF9, 8'h06);
    wait_done(e);
    checks++;
    if (e !== 17 || product !== 16'hFFD6) begin
      failures++;
      $display("FAIL mixed: latency=%0d product=%h required 17/ffd6", e, product);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 16'hFFD6) begin
      failures++;
      $display("FAIL mixed_hold: done=%b busy=%b product=%h required 0/0/ffd6", done, busy, product);
    end
  endtask

  task automatic test_extreme;
    int e;
    pulse_start(8'h80, 8'h80);
    wait_done(e);
    checks++;
    if (e !== 17 || product !== 16'h4000) begin
      failures++;
      $display("FAIL extreme_min_min: latency=%0d product=%h required 17/4000", e, product);
    end
    pulse_start(8'h7F, 8'h80);
    wait_done(e);
    checks++;
    if (e !== 17 || product !== 16'hC080) begin
      failures++;
      $display("FAIL extreme_max_min: latency=%0d product=%h required 17/c080", e, product);
    end
  endtask

  // Ignored starts in RUN/DONE, operand toggling, then a start in the first IDLE cycle.
  task automatic test_back_to_back;
    int ndone;
    int second_at;
    ndone     = 0;
    second_at = -1;
    pulse_start(8'h0C, 8'hFD);
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (k <= 18 && done) ndone++;
      if (k > 18 && done && second_at < 0) second_at = k;
      if (k == 17) begin
        checks++;
        if (done !== 1'b1 || product !== 16'hFFDC) begin
          failures++;
          $display("FAIL isolate_product: done=%b product=%h required 1/ffdc", done, product);
        end
      end
      if (k == 18) begin
        checks++;
        if (busy !== 1'b0 || product !== 16'hFFDC) begin
          failures++;
          $display("FAIL isolate_hold: busy=%b product=%h required 0/ffdc", busy, product);
        end
      end
      if (k == 19) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL idle_accept: busy=%b required 1", busy);
        end
      end
      case (k)
        4:       begin start = 1'b1; a = 8'h7F; b = 8'h7F; end
        5:       start = 1'b0;
        17:      start = 1'b1;
        18:      begin a = 8'd2; b = 8'd3; end
        19:      start = 1'b0;
        default: ;
      endcase
    end
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL single_done: count=%0d required 1", ndone);
    end
    checks++;
    if (second_at !== 36 || product !== 16'h0006) begin
      failures++;
      $display("FAIL second_op: done_at=%0d product=%h required 36/0006", second_at, product);
    end
  endtask

  task automatic test_reset_mid;
    int e;
    pulse_start(8'h33, 8'h44);
    for (int k = 0; k < 8; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_immediate: product=%h busy=%b done=%b required 0000/0/0", product, busy, done);
    end
    for (int i = 0; i < 2; i++) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== 16'h0000) begin
        failures++;
        $display("FAIL reset_mid_quiet: done=%b busy=%b product=%h required 0/0/0000", done, busy, product);
      end
    end
    pulse_start(8'hFF, 8'hFF);
    wait_done(e);
    checks++;
    if (e !== 17 || product !== 16'h0001) begin
      failures++;
      $display("FAIL reset_mid_recover: latency=%0d product=%h required 17/0001", e, product);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    test_reset;
    test_small;
    test_mixed;
    test_extreme;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
